// File: rtl/riscv_glip_arbiter_pkg.sv
// Shared header field positions and FSM state encodings for the GLIP arbiter slice.
package riscv_mpsoc_pkg;

    localparam int unsigned LEN_LSB = 0;
    localparam int unsigned LEN_MSB = 7;
    localparam int unsigned ID_LSB  = 8;
    localparam int unsigned ID_MSB  = 15;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_HDR,
        RX_PAYLOAD,
        RX_DROP
    } rx_state_e;

    function automatic logic [7:0] hdr_len(input logic [15:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [7:0] hdr_id(input logic [15:0] hdr);
        return hdr[ID_MSB:ID_LSB];
    endfunction

endpackage

// File: rtl/riscv_glip_arbiter_if.sv
// GLIP link and per-channel requester streams; slave is the arbiter's view.
interface riscv_glip_arbiter_if #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned CHANNELS = 4
);
    logic [XLEN-1:0]          glip_in_data;
    logic                     glip_in_valid;
    logic                     glip_in_ready;
    logic [XLEN-1:0]          glip_out_data;
    logic                     glip_out_valid;
    logic                     glip_out_ready;
    logic [CHANNELS*XLEN-1:0] ch_tx_data;
    logic [CHANNELS-1:0]      ch_tx_valid;
    logic [CHANNELS-1:0]      ch_tx_ready;
    logic [CHANNELS*XLEN-1:0] ch_rx_data;
    logic [CHANNELS-1:0]      ch_rx_valid;
    logic [CHANNELS-1:0]      ch_rx_ready;

    modport slave (
        input  glip_in_data, glip_in_valid, output glip_in_ready,
        output glip_out_data, glip_out_valid, input glip_out_ready,
        input  ch_tx_data, ch_tx_valid, output ch_tx_ready,
        output ch_rx_data, ch_rx_valid, input ch_rx_ready
    );

    modport master (
        output glip_in_data, glip_in_valid, input glip_in_ready,
        input  glip_out_data, glip_out_valid, output glip_out_ready,
        output ch_tx_data, ch_tx_valid, input ch_tx_ready,
        input  ch_rx_data, ch_rx_valid, output ch_rx_ready
    );
endinterface

// File: rtl/riscv_glip_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module riscv_glip_rr_arbiter #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned IDXW     = 2
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [IDXW-1:0]     ptr_i,
    output logic [CHANNELS-1:0] gnt_oh_o,
    output logic [IDXW-1:0]     gnt_idx_o
);
    logic            found;
    logic [IDXW-1:0] idx;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            idx = IDXW'((32'(ptr_i) + i) % CHANNELS);
            if (!found && req_i[idx]) begin
                found          = 1'b1;
                gnt_idx_o      = idx;
                gnt_oh_o[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_glip_arbiter.sv
// GLIP bridge: TX multiplexes whole requester packets round-robin onto the link,
// RX demultiplexes host packets to the channel named in the header.
module riscv_glip_arbiter
    import riscv_mpsoc_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                clk_logic,
    input  logic                rst,
    input  logic                com_rst,
    riscv_glip_arbiter_if.slave bus,
    output logic [15:0]         rx_drop_cnt
);
    localparam int unsigned IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    tx_state_e           tx_q;
    logic [IDXW-1:0]     grant_q, rr_ptr_q, rr_ptr_d, arb_idx;
    logic [CHANNELS-1:0] arb_oh;
    logic [7:0]          tx_cnt_q, tx_len;
    logic                tx_hdr_q, tx_hs;
    logic [XLEN-1:0]     tx_word;

    rx_state_e           rx_q;
    logic [IDXW-1:0]     dest_q, rx_dest_idx;
    logic [7:0]          rx_dest, rx_len, rx_cnt_q;
    logic                rx_dest_ok, rx_hs, hold_q;
    logic [15:0]         drop_q;

    riscv_glip_rr_arbiter #(.CHANNELS(CHANNELS), .IDXW(IDXW)) u_rr (
        .req_i     (bus.ch_tx_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx)
    );

    assign tx_word     = bus.ch_tx_data[grant_q*XLEN +: XLEN];
    assign tx_len      = hdr_len(tx_word[15:0]);
    assign tx_hs       = bus.glip_out_valid & bus.glip_out_ready;
    assign rr_ptr_d    = (grant_q == IDXW'(CHANNELS - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        bus.glip_out_valid = 1'b0;
        bus.ch_tx_ready    = '0;
        bus.glip_out_data  = tx_word;
        if (tx_q == TX_BUSY) begin
            bus.glip_out_valid       = bus.ch_tx_valid[grant_q];
            bus.ch_tx_ready[grant_q] = bus.glip_out_ready;
            if (tx_hdr_q) begin
                bus.glip_out_data[ID_MSB:ID_LSB] = 8'(grant_q);
            end
        end
    end

    always_ff @(posedge clk_logic) begin
        if (rst || com_rst) begin
            tx_q     <= TX_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            tx_cnt_q <= '0;
            tx_hdr_q <= 1'b0;
        end else begin
            case (tx_q)
                TX_IDLE: begin
                    if (|arb_oh) begin
                        grant_q  <= arb_idx;
                        tx_hdr_q <= 1'b1;
                        tx_q     <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    // Packet end frees the link and advances the round-robin pointer.
                    if (tx_hs) begin
                        if (tx_hdr_q) begin
                            tx_hdr_q <= 1'b0;
                            tx_cnt_q <= tx_len;
                            if (tx_len == 8'd0) begin
                                tx_q     <= TX_IDLE;
                                rr_ptr_q <= rr_ptr_d;
                            end
                        end else begin
                            tx_cnt_q <= tx_cnt_q - 8'd1;
                            if (tx_cnt_q == 8'd1) begin
                                tx_q     <= TX_IDLE;
                                rr_ptr_q <= rr_ptr_d;
                            end
                        end
                    end
                end
                default: tx_q <= TX_IDLE;
            endcase
        end
    end

    assign rx_dest     = hdr_id(bus.glip_in_data[15:0]);
    assign rx_len      = hdr_len(bus.glip_in_data[15:0]);
    assign rx_dest_ok  = 32'(rx_dest) < CHANNELS;
    assign rx_dest_idx = rx_dest[IDXW-1:0];
    assign rx_hs       = bus.glip_in_valid & bus.glip_in_ready;
    assign rx_drop_cnt = drop_q;

    // hold_q keeps the inbound side quiet for the first cycle after any reset.
    always_comb begin
        bus.ch_rx_data    = {CHANNELS{bus.glip_in_data}};
        bus.ch_rx_valid   = '0;
        bus.glip_in_ready = 1'b0;
        if (!hold_q) begin
            case (rx_q)
                RX_HDR: begin
                    if (rx_dest_ok) begin
                        bus.ch_rx_valid[rx_dest_idx] = bus.glip_in_valid;
                        bus.glip_in_ready            = bus.ch_rx_ready[rx_dest_idx];
                    end else begin
                        bus.glip_in_ready = 1'b1;
                    end
                end
                RX_PAYLOAD: begin
                    bus.ch_rx_valid[dest_q] = bus.glip_in_valid;
                    bus.glip_in_ready       = bus.ch_rx_ready[dest_q];
                end
                RX_DROP: bus.glip_in_ready = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_logic) begin
        if (rst || com_rst) begin
            rx_q     <= RX_HDR;
            dest_q   <= '0;
            rx_cnt_q <= '0;
            hold_q   <= 1'b1;
        end else begin
            hold_q <= 1'b0;
            if (rx_hs) begin
                if (rx_q == RX_HDR) begin
                    if (rx_len != 8'd0) begin
                        rx_q     <= rx_dest_ok ? RX_PAYLOAD : RX_DROP;
                        rx_cnt_q <= rx_len;
                        dest_q   <= rx_dest_idx;
                    end
                end else begin
                    rx_cnt_q <= rx_cnt_q - 8'd1;
                    if (rx_cnt_q == 8'd1) begin
                        rx_q <= RX_HDR;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_logic) begin
        if (rst) begin
            drop_q <= '0;
        end else if (!com_rst && rx_hs && rx_q == RX_HDR && !rx_dest_ok && drop_q != '1) begin
            drop_q <= drop_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_riscv_glip_arbiter.sv
// Scoreboard bench for riscv_glip_arbiter: directed packets, expected words queued at issue.
module tb_riscv_glip_arbiter;
    localparam int unsigned XLEN = 64;
    localparam int unsigned CH   = 4;

    typedef struct packed {
        logic [3:0]      ch;
        logic [XLEN-1:0] d;
    } rx_exp_t;

    logic        clk_logic = 1'b0;
    logic        rst, com_rst;
    logic [15:0] rx_drop_cnt;

    always #5 clk_logic = ~clk_logic;

    riscv_glip_arbiter_if #(.XLEN(XLEN), .CHANNELS(CH)) bus ();

    riscv_glip_arbiter #(.XLEN(XLEN), .CHANNELS(CH)) dut (
        .clk_logic   (clk_logic),
        .rst         (rst),
        .com_rst     (com_rst),
        .bus         (bus),
        .rx_drop_cnt (rx_drop_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [XLEN-1:0] txq [CH][$];
    logic [XLEN-1:0] rxq [$];
    logic [XLEN-1:0] exp_out [$];
    rx_exp_t         exp_rx [$];

    logic [CH-1:0] tx_stall, rx_rdy_cfg, rx_valid_seen;
    logic          out_rdy_cfg, rx_toggle;
    int out_hs_cnt, out_first, out_last, in_hs_cnt, in_first, in_last;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] hdr(input logic [7:0] id, input logic [7:0] len,
                                            input logic [47:0] tag);
        return {tag, id, len};
    endfunction

    function automatic logic [XLEN-1:0] pw(input logic [7:0] ch, input logic [47:0] tag, input int k);
        logic [15:0] t;
        t = tag[15:0];
        return {16'hBEEF, t, ch, 24'(k)};
    endfunction

    task automatic load_tx(input int ch, input logic [7:0] id, input int len, input logic [47:0] tag);
        txq[ch].push_back(hdr(id, 8'(len), tag));
        for (int k = 0; k < len; k++) txq[ch].push_back(pw(8'(ch), tag, k));
    endtask

    task automatic exp_tx(input int ch, input int len, input logic [47:0] tag);
        exp_out.push_back(hdr(8'(ch), 8'(len), tag));
        for (int k = 0; k < len; k++) exp_out.push_back(pw(8'(ch), tag, k));
    endtask

    task automatic load_rx(input int dest, input int len, input logic [47:0] tag, input bit routed);
        logic [XLEN-1:0] w;
        for (int k = -1; k < len; k++) begin
            w = (k < 0) ? hdr(8'(dest), 8'(len), tag) : pw(8'hEE, tag, k);
            rxq.push_back(w);
            if (routed) exp_rx.push_back({4'(dest), w});
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < CH; i++) if (txq[i].size() != 0) return 1'b0;
        return rxq.size() == 0 && exp_out.size() == 0 && exp_rx.size() == 0;
    endfunction

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!all_empty() && k < budget) begin
            @(negedge clk_logic); #1;
            k++;
        end
        if (!all_empty()) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: traffic still pending after %0d cycles", budget);
        end
        repeat (2) begin @(negedge clk_logic); #1; end
    endtask

    task automatic wait_out(input int n, input int budget);
        int k = 0;
        while (out_hs_cnt < n && k < budget) begin
            @(negedge clk_logic); #1;
            k++;
        end
        chk("wait_out_hs", 64'(out_hs_cnt >= n), 64'(1));
    endtask

    // Driver: presents queue heads shortly after each rising edge.
    initial begin
        bus.ch_tx_valid    = '0;
        bus.ch_tx_data     = '0;
        bus.glip_in_valid  = 1'b0;
        bus.glip_in_data   = '0;
        bus.glip_out_ready = 1'b0;
        bus.ch_rx_ready    = '0;
        forever begin
            @(posedge clk_logic); #1;
            cyc++;
            for (int i = 0; i < CH; i++) begin
                if (txq[i].size() > 0 && !tx_stall[i]) begin
                    bus.ch_tx_valid[i]             = 1'b1;
                    bus.ch_tx_data[i*XLEN +: XLEN] = txq[i][0];
                end else begin
                    bus.ch_tx_valid[i] = 1'b0;
                end
            end
            if (rxq.size() > 0) begin
                bus.glip_in_valid = 1'b1;
                bus.glip_in_data  = rxq[0];
            end else begin
                bus.glip_in_valid = 1'b0;
            end
            bus.glip_out_ready = out_rdy_cfg;
            bus.ch_rx_ready    = rx_rdy_cfg;
            if (rx_toggle) bus.ch_rx_ready[3] = cyc[0];
        end
    end

    // Monitor: handshakes seen at the falling edge complete on the next rising edge.
    initial begin
        logic [XLEN-1:0] e;
        rx_exp_t         er;
        forever begin
            @(negedge clk_logic);
            for (int i = 0; i < CH; i++)
                if (bus.ch_tx_valid[i] && bus.ch_tx_ready[i] && txq[i].size() > 0)
                    void'(txq[i].pop_front());
            if (bus.glip_out_valid && bus.glip_out_ready) begin
                if (out_hs_cnt == 0) out_first = cyc;
                out_last = cyc;
                out_hs_cnt++;
                if (exp_out.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got %h required no word", bus.glip_out_data);
                end else begin
                    e = exp_out.pop_front();
                    chk("out_word", bus.glip_out_data, e);
                end
            end
            rx_valid_seen = rx_valid_seen | bus.ch_rx_valid;
            if (bus.glip_in_valid && bus.glip_in_ready) begin
                if (in_hs_cnt == 0) in_first = cyc;
                in_last = cyc;
                in_hs_cnt++;
                if (rxq.size() > 0) void'(rxq.pop_front());
            end
            for (int i = 0; i < CH; i++) begin
                if (bus.ch_rx_valid[i] && bus.ch_rx_ready[i]) begin
                    if (exp_rx.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_unexpected: got ch%0d %h required no word", i,
                                 bus.ch_rx_data[i*XLEN +: XLEN]);
                    end else begin
                        er = exp_rx.pop_front();
                        chk("rx_chan", 64'(i), 64'(er.ch));
                        chk("rx_word", bus.ch_rx_data[i*XLEN +: XLEN], er.d);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; com_rst = 1'b0;
        tx_stall = '0; rx_rdy_cfg = '1; rx_valid_seen = '0;
        out_rdy_cfg = 1'b1; rx_toggle = 1'b0;
        out_hs_cnt = 0; out_first = 0; out_last = 0;
        in_hs_cnt = 0; in_first = 0; in_last = 0;

        repeat (3) @(posedge clk_logic);
        @(negedge clk_logic); #1;
        chk("rst_out_valid", 64'(bus.glip_out_valid), 64'(0));
        chk("rst_tx_ready",  64'(bus.ch_tx_ready),    64'(0));
        chk("rst_in_ready",  64'(bus.glip_in_ready),  64'(0));
        chk("rst_rx_valid",  64'(bus.ch_rx_valid),    64'(0));
        chk("rst_drop_cnt",  64'(rx_drop_cnt),        64'(0));
        rst = 1'b0;
        repeat (2) begin @(negedge clk_logic); #1; end

        // Contention ch0/ch2 from pointer 0: ch0 first.
        load_tx(0, 8'h00, 1, 48'h1111); load_tx(2, 8'h00, 2, 48'h2222);
        exp_tx(0, 1, 48'h1111); exp_tx(2, 2, 48'h2222);
        wait_idle(60);

        // Lone ch0 packet moves the pointer to 1; then ch2 wins the next contention.
        load_tx(0, 8'h05, 0, 48'h3333); exp_tx(0, 0, 48'h3333);
        wait_idle(30);
        load_tx(0, 8'h00, 1, 48'h4444); load_tx(2, 8'h00, 1, 48'h5555);
        exp_tx(2, 1, 48'h5555); exp_tx(0, 1, 48'h4444);
        wait_idle(60);

        // Ch1 LEN=2: one bubble, three back-to-back words, source stamp over 0xAB.
        out_hs_cnt = 0;
        load_tx(1, 8'hAB, 2, 48'h6666); exp_tx(1, 2, 48'h6666);
        @(negedge clk_logic); #1;
        chk("bubble_valid", 64'(bus.glip_out_valid), 64'(0));
        chk("bubble_ready", 64'(bus.ch_tx_ready),    64'(0));
        @(negedge clk_logic); #1;
        chk("first_valid", 64'(bus.glip_out_valid), 64'(1));
        chk("first_stamp", bus.glip_out_data, hdr(8'h01, 8'd2, 48'h6666));
        wait_idle(30);
        chk("ch1_words",  64'(out_hs_cnt),            64'(3));
        chk("ch1_span",   64'(out_last - out_first),  64'(2));
        chk("ch1_idle",   64'(bus.glip_out_valid),    64'(0));

        // Mid-packet valid drop stalls the link; ch1 must wait.
        out_hs_cnt = 0;
        load_tx(0, 8'h00, 3, 48'h7777); exp_tx(0, 3, 48'h7777); exp_tx(1, 1, 48'h8888);
        wait_out(1, 20);
        tx_stall[0] = 1'b1;
        load_tx(1, 8'h00, 1, 48'h8888);
        repeat (3) begin
            @(negedge clk_logic); #1;
            chk("stall_valid", 64'(bus.glip_out_valid),  64'(0));
            chk("stall_other", 64'(bus.ch_tx_ready[1]),  64'(0));
            chk("stall_grant", 64'(bus.ch_tx_ready[0]),  64'(1));
        end
        tx_stall[0] = 1'b0;
        wait_idle(60);

        // Host packet to ch3 with toggling ready.
        in_hs_cnt = 0; rx_valid_seen = '0; rx_toggle = 1'b1;
        load_rx(3, 4, 48'h9999, 1'b1);
        wait_idle(100);
        rx_toggle = 1'b0;
        chk("rx3_words", 64'(in_hs_cnt),     64'(5));
        chk("rx3_only",  64'(rx_valid_seen), 64'(4'b1000));

        // Invalid destinations are swallowed and counted.
        in_hs_cnt = 0; rx_valid_seen = '0;
        load_rx(9, 2, 48'hAAAA, 1'b0);
        wait_idle(40);
        chk("drop_words", 64'(in_hs_cnt),     64'(3));
        chk("drop_cnt1",  64'(rx_drop_cnt),   64'(1));
        chk("drop_novld", 64'(rx_valid_seen), 64'(0));
        load_rx(4, 0, 48'hBBBB, 1'b0);
        load_rx(3, 0, 48'hCCCC, 1'b1);
        wait_idle(40);
        chk("drop_cnt2", 64'(rx_drop_cnt), 64'(2));

        // com_rst after header+1 payload of a LEN=3 ch3 packet.
        out_hs_cnt = 0;
        load_tx(3, 8'h00, 3, 48'hDDDD);
        exp_out.push_back(hdr(8'h03, 8'd3, 48'hDDDD));
        exp_out.push_back(pw(8'h03, 48'hDDDD, 0));
        wait_out(2, 20);
        com_rst = 1'b1;
        txq[3].delete();
        @(posedge clk_logic); #1;
        com_rst = 1'b0;
        @(negedge clk_logic); #1;
        chk("crst_out_valid", 64'(bus.glip_out_valid), 64'(0));
        chk("crst_tx_ready",  64'(bus.ch_tx_ready),    64'(0));
        chk("crst_in_ready",  64'(bus.glip_in_ready),  64'(0));
        chk("crst_rx_valid",  64'(bus.ch_rx_valid),    64'(0));
        chk("crst_drop_held", 64'(rx_drop_cnt),        64'(2));
        chk("crst_exp_empty", 64'(exp_out.size()),     64'(0));
        // Pointer back at 0: ch1 beats ch3.
        load_tx(1, 8'h00, 0, 48'hEEEE); load_tx(3, 8'h00, 0, 48'hFFFF);
        exp_tx(1, 0, 48'hEEEE); exp_tx(3, 0, 48'hFFFF);
        wait_idle(40);

        // Full duplex, 256 words each way, all readies high.
        out_hs_cnt = 0; in_hs_cnt = 0;
        load_tx(2, 8'h00, 255, 48'h1234); exp_tx(2, 255, 48'h1234);
        load_rx(0, 255, 48'h5678, 1'b1);
        wait_idle(600);
        chk("dup_tx_words", 64'(out_hs_cnt),         64'(256));
        chk("dup_tx_span",  64'(out_last - out_first), 64'(255));
        chk("dup_rx_words", 64'(in_hs_cnt),          64'(256));
        chk("dup_rx_span",  64'(in_last - in_first),   64'(255));
        chk("final_drop",   64'(rx_drop_cnt),        64'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
